// File: rtl/kf76489_pkg.sv
// kf76489_pkg
//   Shared types and constants for the KF76489 sound core write path.
//   - reg_code_t   : latched register code, encoded as {channel[1:0], is_attenuation}
//   - wc_state_t   : write controller FSM state
//   - byte field bit positions of a CPU byte (bit0 = latch flag)
//   - helpers to split a register code into channel and type
package kf76489_pkg;

   // Encoding is {channel, type} so that the channel and the attenuation
   // flag can be pulled straight out of the code bits.
   typedef enum logic [2:0] {
      TONE0_FREQ = 3'd0,
      TONE0_ATT  = 3'd1,
      TONE1_FREQ = 3'd2,
      TONE1_ATT  = 3'd3,
      TONE2_FREQ = 3'd4,
      TONE2_ATT  = 3'd5,
      NOISE_CTRL = 3'd6,
      NOISE_ATT  = 3'd7
   } reg_code_t;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_STROBE       = 2'd1,
      ST_BUSY         = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } wc_state_t;

   // Byte fields: channel is {bit1, bit2} with bit1 as the MSB.
   localparam int LATCH_BIT  = 0;
   localparam int CH_MSB_BIT = 1;
   localparam int CH_LSB_BIT = 2;
   localparam int TYPE_BIT   = 3;

   function automatic logic [1:0] reg_channel(input reg_code_t code);
      return code[2:1];
   endfunction

   function automatic logic reg_is_att(input reg_code_t code);
      return code[0];
   endfunction

endpackage

// File: rtl/kf76489_clock_divider.sv
// kf76489_clock_divider
//   Free-running prescaler producing a one-clock enable pulse every
//   CLOCK_DIV clocks. Shared by the clocked blocks of the sound core.
//   Ports:
//     clock        in   system clock
//     reset        in   asynchronous, active-high reset
//     clock_enable out  high for the single cycle where the count is zero
module kf76489_clock_divider #(
   parameter int CLOCK_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   output logic clock_enable
);

   localparam int CW = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLOCK_DIV - 1);

   logic [CW-1:0] count;

   // Down-counter: reset and reload both start at CLOCK_DIV-1, so the first
   // pulse after reset arrives CLOCK_DIV-1 clocks later.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= RELOAD;
      end else if (count == '0) begin
         count <= RELOAD;
      end else begin
         count <= count - CW'(1);
      end
   end

   assign clock_enable = (count == '0);

endmodule

// File: rtl/kf76489_write_controller.sv
// kf76489_write_controller
//   CPU write interface and register sequencer of the KF76489 sound core.
//   Accepts SN76489-style latch/data bytes, tracks the latched register and
//   turns every accepted byte into a single-cycle write strobe, while holding
//   the byte on internal_data_bus.
//   Ports:
//     clock, reset         system clock, asynchronous active-high reset
//     chip_select_n        active-low chip select
//     write_enable_n       active-low write enable
//     data_bus_in[7:0]     CPU byte (bit0 = latch flag)
//     ready                1 = idle, 0 = write in progress
//     clock_enable         prescaler pulse, one clock every CLOCK_DIV clocks
//     internal_data_bus    last accepted byte
//     write_frequency_h    per-tone strobe, latch byte into tone frequency
//     write_frequency_l    per-tone strobe, data byte into tone frequency
//     write_attenuation    per-channel attenuation strobe (index 3 = noise)
//     write_noise_control  noise control register strobe
//   Handshake: a request (chip_select_n and write_enable_n both low) is only
//   taken while ready is high and the FSM is idle; ready then stays low for
//   BUSY_CYCLES clocks, and a request still held afterwards is not taken
//   again until it has been released.
module kf76489_write_controller
   import kf76489_pkg::*;
#(
   parameter int BUSY_CYCLES = 32,
   parameter int CLOCK_DIV   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       chip_select_n,
   input  logic       write_enable_n,
   input  logic [7:0] data_bus_in,
   output logic       ready,
   output logic       clock_enable,
   output logic [7:0] internal_data_bus,
   output logic [2:0] write_frequency_h,
   output logic [2:0] write_frequency_l,
   output logic [3:0] write_attenuation,
   output logic       write_noise_control
);

   localparam int BW = (BUSY_CYCLES > 2) ? $clog2(BUSY_CYCLES) : 1;
   // STROBE takes one of the busy clocks and BUSY exits when the count is
   // zero, so the load value is two short of the busy length.
   localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_CYCLES - 2);

   wc_state_t     state, state_next;
   reg_code_t     reg_code, reg_code_next;
   logic [7:0]    data_reg, data_next;
   logic [BW-1:0] busy_count, busy_count_next;
   logic          released, released_next;
   logic          request;
   logic [3:0]    ch_onehot;

   assign request = ~chip_select_n & ~write_enable_n;

   kf76489_clock_divider #(
      .CLOCK_DIV(CLOCK_DIV)
   ) u_clock_divider (
      .clock       (clock),
      .reset       (reset),
      .clock_enable(clock_enable)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         reg_code   <= TONE0_FREQ;
         data_reg   <= 8'h00;
         busy_count <= '0;
         released   <= 1'b0;
      end else begin
         state      <= state_next;
         reg_code   <= reg_code_next;
         data_reg   <= data_next;
         busy_count <= busy_count_next;
         released   <= released_next;
      end
   end

   always_comb begin
      state_next      = state;
      reg_code_next   = reg_code;
      data_next       = data_reg;
      busy_count_next = busy_count;
      released_next   = released;
      case (state)
         ST_IDLE: begin
            if (request) begin
               data_next       = data_bus_in;
               busy_count_next = BUSY_LOAD;
               released_next   = 1'b0;
               state_next      = ST_STROBE;
               if (data_bus_in[LATCH_BIT]) begin
                  reg_code_next = reg_code_t'({data_bus_in[CH_MSB_BIT],
                                               data_bus_in[CH_LSB_BIT],
                                               data_bus_in[TYPE_BIT]});
               end
            end
         end
         ST_STROBE: begin
            if (!request) released_next = 1'b1;
            state_next = ST_BUSY;
         end
         ST_BUSY: begin
            if (!request) released_next = 1'b1;
            if (busy_count == '0) begin
               // A request that was never dropped must not write twice.
               state_next = (released || !request) ? ST_IDLE : ST_WAIT_RELEASE;
            end else begin
               busy_count_next = busy_count - BW'(1);
            end
         end
         ST_WAIT_RELEASE: begin
            if (!request) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign ch_onehot = 4'b0001 << reg_channel(reg_code);

   // Strobes decode from registered state only, so they are exclusive and
   // confined to the STROBE cycle.
   always_comb begin
      write_frequency_h   = 3'b000;
      write_frequency_l   = 3'b000;
      write_attenuation   = 4'b0000;
      write_noise_control = 1'b0;
      if (state == ST_STROBE) begin
         if (reg_is_att(reg_code)) begin
            write_attenuation = ch_onehot;
         end else if (reg_code == NOISE_CTRL) begin
            write_noise_control = 1'b1;
         end else if (data_reg[LATCH_BIT]) begin
            write_frequency_h = ch_onehot[2:0];
         end else begin
            write_frequency_l = ch_onehot[2:0];
         end
      end
   end

   assign ready             = (state == ST_IDLE) || (state == ST_WAIT_RELEASE);
   assign internal_data_bus = data_reg;

endmodule

// File: tb/tb_kf76489_write_controller.sv
module tb_kf76489_write_controller;

   localparam int BUSY_CYCLES = 32;
   localparam int CLOCK_DIV   = 4;

   logic       clock;
   logic       reset;
   logic       chip_select_n;
   logic       write_enable_n;
   logic [7:0] data_bus_in;
   logic       ready;
   logic       clock_enable;
   logic [7:0] internal_data_bus;
   logic [2:0] write_frequency_h;
   logic [2:0] write_frequency_l;
   logic [3:0] write_attenuation;
   logic       write_noise_control;

   logic [10:0] strobe_vec;
   assign strobe_vec = {write_frequency_h, write_frequency_l,
                        write_attenuation, write_noise_control};

   int n_checks = 0;
   int n_fail   = 0;

   logic [10:0] exp_q[$];

   // Reference model of the latched register: channel 0..3, attenuation flag.
   int   m_ch  = 0;
   logic m_att = 1'b0;

   kf76489_write_controller #(
      .BUSY_CYCLES(BUSY_CYCLES),
      .CLOCK_DIV  (CLOCK_DIV)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .chip_select_n      (chip_select_n),
      .write_enable_n     (write_enable_n),
      .data_bus_in        (data_bus_in),
      .ready              (ready),
      .clock_enable       (clock_enable),
      .internal_data_bus  (internal_data_bus),
      .write_frequency_h  (write_frequency_h),
      .write_frequency_l  (write_frequency_l),
      .write_attenuation  (write_attenuation),
      .write_noise_control(write_noise_control)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic void model_reset();
      m_ch  = 0;
      m_att = 1'b0;
   endfunction

   // Expected {freq_h, freq_l, attenuation, noise} for an accepted byte.
   function automatic logic [10:0] model_accept(input logic [7:0] b);
      logic [2:0] fh;
      logic [2:0] fl;
      logic [3:0] at;
      logic       nz;
      fh = 3'b000; fl = 3'b000; at = 4'b0000; nz = 1'b0;
      if (b[0]) begin
         m_ch  = 2 * int'(b[1]) + int'(b[2]);
         m_att = b[3];
      end
      if (m_att)          at = 4'(1 << m_ch);
      else if (m_ch == 3) nz = 1'b1;
      else if (b[0])      fh = 3'(1 << m_ch);
      else                fl = 3'(1 << m_ch);
      return {fh, fl, at, nz};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic release_bus();
      chip_select_n  = 1'b1;
      write_enable_n = 1'b1;
      data_bus_in    = 8'($urandom_range(0, 255));
   endtask

   // Drives one access held for 'hold' clocks and reports what was seen:
   // strobes and bus in the cycle after acceptance, number of sampled
   // ready-low cycles, and any strobe activity after that first cycle.
   task automatic write_byte(input logic [7:0] b, input int hold,
                             output logic [10:0] stb, output logic [7:0] bus,
                             output int low, output int extra);
      @(posedge clock); #1;
      chip_select_n  = 1'b0;
      write_enable_n = 1'b0;
      data_bus_in    = b;
      @(posedge clock); #1;
      stb   = strobe_vec;
      bus   = internal_data_bus;
      low   = 0;
      extra = 0;
      for (int t = 1; t <= hold + 200; t++) begin
         if (ready === 1'b0) low++;
         if (t > 1 && strobe_vec !== 11'd0) extra++;
         if (t == hold) release_bus();
         if (t >= hold && ready === 1'b1) break;
         @(posedge clock); #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int pulses[$];
      reset = 1'b1;
      release_bus();
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 1", ready);
      end
      n_checks++;
      if (strobe_vec !== 11'd0) begin
         n_fail++; $display("FAIL reset_strobes: got %b expected 0", strobe_vec);
      end
      n_checks++;
      if (internal_data_bus !== 8'h00) begin
         n_fail++; $display("FAIL reset_bus: got %h expected 00", internal_data_bus);
      end
      n_checks++;
      if (clock_enable !== 1'b0) begin
         n_fail++; $display("FAIL reset_clock_enable: got %b expected 0", clock_enable);
      end
      reset = 1'b0;
      for (int t = 1; t <= 5 * CLOCK_DIV; t++) begin
         @(posedge clock); #1;
         if (clock_enable === 1'b1) pulses.push_back(t);
      end
      n_checks++;
      if (pulses.size() != 5) begin
         n_fail++; $display("FAIL ce_pulse_count: got %0d expected 5", pulses.size());
      end
      n_checks++;
      if (pulses.size() == 0 || pulses[0] != CLOCK_DIV - 1) begin
         n_fail++; $display("FAIL ce_first_pulse: got %0d expected %0d",
                            (pulses.size() == 0) ? -1 : pulses[0], CLOCK_DIV - 1);
      end
      for (int i = 1; i < pulses.size(); i++) begin
         n_checks++;
         if (pulses[i] - pulses[i-1] != CLOCK_DIV) begin
            n_fail++; $display("FAIL ce_period: got %0d expected %0d",
                               pulses[i] - pulses[i-1], CLOCK_DIV);
         end
      end
   endtask

   // Checks a fixed pair of writes: latch byte then data byte.
   task automatic test_pair(input string name, input logic [7:0] b_latch,
                            input logic [7:0] b_data,
                            input logic [10:0] lit_latch, input logic [10:0] lit_data);
      logic [10:0] stb, exp_stb;
      logic [7:0]  bus;
      int          low, extra;
      logic [7:0]  bytes [2];
      logic [10:0] lits  [2];
      bytes[0] = b_latch; bytes[1] = b_data;
      lits[0]  = lit_latch; lits[1] = lit_data;
      for (int i = 0; i < 2; i++) begin
         exp_stb = model_accept(bytes[i]);
         write_byte(bytes[i], 1, stb, bus, low, extra);
         n_checks++;
         if (stb !== exp_stb || stb !== lits[i]) begin
            n_fail++; $display("FAIL %s_strobe%0d: got %b expected %b", name, i, stb, lits[i]);
         end
         n_checks++;
         if (bus !== bytes[i]) begin
            n_fail++; $display("FAIL %s_bus%0d: got %h expected %h", name, i, bus, bytes[i]);
         end
         n_checks++;
         if (low != BUSY_CYCLES) begin
            n_fail++; $display("FAIL %s_busy%0d: got %0d expected %0d", name, i, low, BUSY_CYCLES);
         end
         n_checks++;
         if (extra != 0) begin
            n_fail++; $display("FAIL %s_extra%0d: got %0d expected 0", name, i, extra);
         end
      end
   endtask

   task automatic test_held();
      logic [10:0] stb, exp_stb;
      logic [7:0]  bus;
      int          low, extra;
      exp_stb = model_accept(8'hA5);
      write_byte(8'hA5, 100, stb, bus, low, extra);
      n_checks++;
      if (stb !== exp_stb) begin
         n_fail++; $display("FAIL held_strobe: got %b expected %b", stb, exp_stb);
      end
      n_checks++;
      if (low != BUSY_CYCLES) begin
         n_fail++; $display("FAIL held_busy: got %0d expected %0d", low, BUSY_CYCLES);
      end
      n_checks++;
      if (extra != 0) begin
         n_fail++; $display("FAIL held_extra: got %0d expected 0", extra);
      end
      exp_stb = model_accept(8'h12);
      write_byte(8'h12, 1, stb, bus, low, extra);
      n_checks++;
      if (stb !== exp_stb || bus !== 8'h12) begin
         n_fail++; $display("FAIL held_next: got %b/%h expected %b/12", stb, bus, exp_stb);
      end
   endtask

   // Release and re-assert during BUSY: the byte present at re-acceptance wins.
   task automatic test_back_to_back();
      logic [7:0]  b1, b3;
      logic [10:0] e1, e3;
      int          gap;
      bit          seen;
      b1 = 8'($urandom_range(0, 255)) | 8'h01;
      b3 = 8'($urandom_range(0, 255));
      e1 = model_accept(b1);
      e3 = model_accept(b3);
      @(posedge clock); #1;
      chip_select_n = 1'b0; write_enable_n = 1'b0; data_bus_in = b1;
      @(posedge clock); #1;
      n_checks++;
      if (strobe_vec !== e1) begin
         n_fail++; $display("FAIL b2b_first: got %b expected %b", strobe_vec, e1);
      end
      release_bus();
      repeat (10) begin @(posedge clock); #1; end
      chip_select_n = 1'b0; write_enable_n = 1'b0; data_bus_in = ~b3;
      repeat (10) begin @(posedge clock); #1; end
      data_bus_in = b3;
      seen = 1'b0;
      gap  = 0;
      for (int t = 20; t < 100; t++) begin
         if (strobe_vec !== 11'd0) begin
            gap = t; seen = 1'b1; break;
         end
         @(posedge clock); #1;
      end
      n_checks++;
      if (!seen || gap != BUSY_CYCLES + 1) begin
         n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", gap, BUSY_CYCLES + 1);
      end
      n_checks++;
      if (strobe_vec !== e3 || internal_data_bus !== b3) begin
         n_fail++; $display("FAIL b2b_second: got %b/%h expected %b/%h",
                            strobe_vec, internal_data_bus, e3, b3);
      end
      release_bus();
      for (int t = 0; t < BUSY_CYCLES + 10 && ready !== 1'b1; t++) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset_mid_busy();
      logic [10:0] stb, exp_stb;
      logic [7:0]  bus;
      int          low, extra;
      @(posedge clock); #1;
      chip_select_n = 1'b0; write_enable_n = 1'b0; data_bus_in = 8'h5B;
      @(posedge clock); #1;
      release_bus();
      repeat (9) begin @(posedge clock); #1; end
      reset = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (ready !== 1'b1 || internal_data_bus !== 8'h00 || strobe_vec !== 11'd0) begin
         n_fail++; $display("FAIL midreset_state: got ready=%b bus=%h stb=%b expected 1/00/0",
                            ready, internal_data_bus, strobe_vec);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
         n_checks++;
         if (strobe_vec !== 11'd0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_quiet: got stb=%b ready=%b expected 0/1",
                               strobe_vec, ready);
         end
      end
      exp_stb = model_accept(8'hFC);
      write_byte(8'hFC, 1, stb, bus, low, extra);
      n_checks++;
      if (stb !== exp_stb || stb !== {3'b000, 3'b001, 4'b0000, 1'b0}) begin
         n_fail++; $display("FAIL midreset_data: got %b expected %b", stb, exp_stb);
      end
   endtask

   task automatic test_random();
      logic [10:0] stb, exp_stb;
      logic [7:0]  bus, b;
      int          low, extra, hold;
      for (int i = 0; i < 30; i++) begin
         b    = 8'($urandom_range(0, 255));
         hold = ($urandom_range(0, 5) == 0) ? 40 : int'($urandom_range(1, 3));
         exp_q.push_back(model_accept(b));
         write_byte(b, hold, stb, bus, low, extra);
         exp_stb = exp_q.pop_front();
         n_checks++;
         if (stb !== exp_stb || bus !== b) begin
            n_fail++; $display("FAIL rand%0d_write: byte %h got %b/%h expected %b/%h",
                               i, b, stb, bus, exp_stb, b);
         end
         n_checks++;
         if (low != BUSY_CYCLES || extra != 0) begin
            n_fail++; $display("FAIL rand%0d_timing: got low=%0d extra=%0d expected %0d/0",
                               i, low, extra, BUSY_CYCLES);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset          = 1'b1;
      chip_select_n  = 1'b1;
      write_enable_n = 1'b1;
      data_bus_in    = 8'h00;
      test_reset();
      test_pair("tone1", 8'hA5, 8'hFC,
                {3'b010, 3'b000, 4'b0000, 1'b0}, {3'b000, 3'b010, 4'b0000, 1'b0});
      test_pair("tone2att", 8'h5B, 8'h30,
                {3'b000, 3'b000, 4'b0100, 1'b0}, {3'b000, 3'b000, 4'b0100, 1'b0});
      test_pair("noise", 8'h47, 8'h80,
                {3'b000, 3'b000, 4'b0000, 1'b1}, {3'b000, 3'b000, 4'b0000, 1'b1});
      test_held();
      test_back_to_back();
      test_reset_mid_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
